// File: rtl/shift_result_serializer.sv
// Buffers shifter result words in a FIFO and streams each one MSB-first on a 1-bit valid/ready link.
// Define PARITY_EN to append an even-parity bit to every frame.
module shift_result_serializer #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

`ifdef PARITY_EN
    localparam int unsigned FRAME = N + 1;
`else
    localparam int unsigned FRAME = N;
`endif
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(FRAME);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]   level_q, level_d;
    logic [FRAME-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME-1:0]  head_frame;
    logic              push, pop, fifo_empty, last_bit;

    assign fifo_empty = (level_q == '0);
    assign in_ready   = (level_q != LvlW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign last_bit   = (bit_cnt_q == CntW'(FRAME - 1));
    assign fifo_level = level_q;

    // The shift register holds the whole frame, so parity rides along as its LSB.
`ifdef PARITY_EN
    assign head_frame = {mem_q[rd_ptr_q], ^mem_q[rd_ptr_q]};
`else
    assign head_frame = mem_q[rd_ptr_q];
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        busy      = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = head_frame;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = shreg_q[FRAME-1];
                ser_last  = last_bit;
                if (ser_ready) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            shreg_d   = head_frame;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign level_d = level_q + LvlW'(push) - LvlW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the level counter gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_shift_result_serializer.sv
// Scoreboard bench for shift_result_serializer: accepted words queue their expected bits,
// a monitor pops and compares on every accepted serial bit.
module tb_shift_result_serializer;

`ifdef PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk, rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic       ser_out, ser_valid, ser_ready, ser_last;
    logic [2:0] fifo_level;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {logic b; logic l;} exp_t;
    exp_t sbq[$];

    shift_result_serializer #(.N(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (ser_last),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enqueue(input logic [7:0] d);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            e.b = d[i];
`ifdef PARITY_EN
            e.l = 1'b0;
`else
            e.l = (i == 0);
`endif
            sbq.push_back(e);
        end
`ifdef PARITY_EN
        e.b = ^d;
        e.l = 1'b1;
        sbq.push_back(e);
`endif
    endtask

    // Scoreboard input side: record every accepted word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) enqueue(in_data);
        end
    end

    // Monitor: check stall stability and every accepted bit.
    initial begin
        logic prev_stall, prev_out, prev_last;
        exp_t e;
        prev_stall = 1'b0;
        prev_out   = 1'b0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", ser_valid, 1);
                    chk("stall_out", ser_out, prev_out);
                    chk("stall_last", ser_last, prev_last);
                end
                if (ser_valid && ser_ready) begin
                    chk("bit_expected", sbq.size() > 0, 1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("ser_out", ser_out, e.b);
                        chk("ser_last", ser_last, e.l);
                    end
                end
                prev_stall = ser_valid && !ser_ready;
                prev_out   = ser_out;
                prev_last  = ser_last;
            end
        end
    end

    task automatic push_word(input logic [7:0] d);
        int n;
        logic acc;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        chk("push_accepted", acc, 1);
    endtask

    // gap: idle negedges before ser_valid rises; len: consecutive valid negedges.
    task automatic run_len(output int len, output int gap);
        len = 0;
        gap = 0;
        @(negedge clk);
        while (!ser_valid && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        while (ser_valid && len < 300) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_ser_valid"}, ser_valid, 0);
        chk({tag, "_ser_out"}, ser_out, 0);
        chk({tag, "_ser_last"}, ser_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int len, gap, n;
        logic seen;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ser_ready = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single word, full-rate consumer
        ser_ready = 1'b1;
        push_word(8'hA5);
        run_len(len, gap);
        chk("t1_latency_gap", gap, 1);
        chk("t1_len", len, FRAME);
        chk("t1_busy_after", busy, 0);

        // 2: back-to-back frames with no idle cycle
        @(posedge clk);
        #1;
        push_word(8'h80);
        push_word(8'h01);
        run_len(len, gap);
        chk("t2_len", len, 2 * FRAME);

        // 3: fill to capacity while the consumer stalls
        @(posedge clk);
        #1 ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'h11 + 8'(i));
        in_data  = 8'h16;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t3_full_in_ready", in_ready, 0);
        chk("t3_full_level", fifo_level, 4);
        chk("t3_busy", busy, 1);
        @(posedge clk);
        #1 ser_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        chk("t3_ready_return", n, FRAME + 1);
        chk("t3_level_after_frame", fifo_level, 3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || fifo_level != 0) && n < 300);
        chk("t3_drained_busy", busy, 0);
        chk("t3_drained_level", fifo_level, 0);

        // 4: alternating stalls
        @(posedge clk);
        #1 ser_ready = 1'b0;
        push_word(8'hF0);
        @(posedge clk);
        #1;
        len = 0;
        for (int c = 0; c < 100; c++) begin
            ser_ready = c[0];
            @(negedge clk);
            if (!ser_valid) break;
            len++;
            @(posedge clk);
            #1;
        end
        chk("t4_len", len, 2 * FRAME);

        // 5: reset mid-frame with words queued
        @(posedge clk);
        #1 ser_ready = 1'b0;
        push_word(8'hC3);
        push_word(8'h55);
        push_word(8'hAA);
        chk("t5_level_before", fifo_level, 2);
        ser_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 ser_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        sbq.delete();
        check_reset_outputs("t5");
        @(posedge clk);
        #1 rst_n = 1'b1;
        ser_ready = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ser_valid) seen = 1'b1;
        end
        chk("t5_no_residual", seen, 0);
        chk("t5_level_after", fifo_level, 0);

        // 6: parity frames (plain frames when parity is not built in)
        @(posedge clk);
        #1;
        push_word(8'hA5);
        push_word(8'h07);
        run_len(len, gap);
        chk("t6_len", len, 2 * FRAME);
        chk("t6_busy_after", busy, 0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
